fifo_unpack: RTL and testbench

- Reads the byte stream produced by the drift-board packetiser out of the readout FIFO and reassembles the packets into parallel words.
- Trigger packets become a trigger number plus a 36-bit trigger time; cycle packets become a cycle number.
- Sits on the FIFO read side, in the readout/control FPGA path, single clock domain.
- Detects framing errors and resynchronises on the next header byte.

---
 rtl/fifo_unpack_if.sv | 39 +++
 rtl/fifo_unpack.sv | 150 +++++++++++++++
 tb/tb_fifo_unpack.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_unpack_if.sv
// Bus between the readout FIFO read side, the unpacker and the packet consumer.
// The unpacker drives through the master modport; the FIFO/consumer side uses slave.
interface fifo_unpack_if #(
    parameter int ERRW = 16
) ();
    logic [7:0]      fifo_data;
    logic            fifo_empty;
    logic            fifo_rd;
    logic            trig_valid;
    logic [17:0]     trig_num;
    logic [35:0]     trig_time;
    logic            cycle_valid;
    logic [17:0]     cycle_num;
    logic [ERRW-1:0] err_cnt;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd,
        output trig_valid,
        output trig_num,
        output trig_time,
        output cycle_valid,
        output cycle_num,
        output err_cnt
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd,
        input  trig_valid,
        input  trig_num,
        input  trig_time,
        input  cycle_valid,
        input  cycle_num,
        input  err_cnt
    );
endinterface

// File: rtl/fifo_unpack.sv
// Reassembles drift-board trigger/cycle packets from the readout FIFO byte stream.
// Header bytes: 0xFF trigger, 0xBF cycle; payload bytes carry 6 bits, LSB chunk first.
// The interface ERRW must match this module's ERRW.
module fifo_unpack #(
    parameter int TIMEOUT = 1024,
    parameter int ERRW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_unpack_if.master bus
);
    // Stall counter only has to count up to TIMEOUT-1; the abort fires on the next stall.
    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STALL_LAST = (TIMEOUT > 0) ? SW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        CYC  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [3:0]      idx_reg;
    logic            fifo_rd_reg;
    logic            byte_vld_reg;
    logic [SW-1:0]   stall_reg;
    logic            trig_valid_reg;
    logic            cycle_valid_reg;
    logic [17:0]     trig_num_reg;
    logic [35:0]     trig_time_reg;
    logic [17:0]     cycle_num_reg;
    logic [ERRW-1:0] err_cnt_reg;

    // Shadow slots for all but the last chunk; the last chunk comes straight off fifo_data.
    logic [5:0]      trig_sh [0:7];
    logic [5:0]      cyc_sh  [0:1];
    logic [53:0]     trig_cat;
    logic [17:0]     cyc_cat;

    logic            is_th;
    logic            is_ch;
    logic            is_pay;
    logic [5:0]      payload;

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Classify the byte currently on fifo_data.
    always_comb begin
        payload = bus.fifo_data[5:0];
        is_th   = (bus.fifo_data == 8'hFF);
        is_ch   = (bus.fifo_data == 8'hBF);
        is_pay  = (bus.fifo_data[7:6] == 2'b00);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_trig_cat
            assign trig_cat[6*gi +: 6] = trig_sh[gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_cyc_cat
            assign cyc_cat[6*gi +: 6] = cyc_sh[gi];
        end
    endgenerate
    assign trig_cat[53:48] = payload;
    assign cyc_cat[17:12]  = payload;

    // Read pipeline, packet FSM, timeout and error counting with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            fifo_rd_reg     <= 1'b0;
            byte_vld_reg    <= 1'b0;
            stall_reg       <= '0;
            trig_valid_reg  <= 1'b0;
            cycle_valid_reg <= 1'b0;
            trig_num_reg    <= '0;
            trig_time_reg   <= '0;
            cycle_num_reg   <= '0;
            err_cnt_reg     <= '0;
        end else begin
            fifo_rd_reg     <= !bus.fifo_empty;
            byte_vld_reg    <= fifo_rd_reg;
            trig_valid_reg  <= 1'b0;
            cycle_valid_reg <= 1'b0;

            if (byte_vld_reg) begin
                stall_reg <= '0;
                if (is_th || is_ch) begin
                    // A header inside a packet abandons it and starts over.
                    if (state_reg != IDLE)
                        err_cnt_reg <= sat_inc(err_cnt_reg);
                    state_reg <= is_th ? TRIG : CYC;
                    idx_reg   <= '0;
                end else if (is_pay) begin
                    case (state_reg)
                        TRIG: begin
                            if (idx_reg == 4'd8) begin
                                trig_valid_reg <= 1'b1;
                                trig_num_reg   <= trig_cat[17:0];
                                trig_time_reg  <= trig_cat[53:18];
                                state_reg      <= IDLE;
                            end else begin
                                trig_sh[idx_reg[2:0]] <= payload;
                                idx_reg               <= idx_reg + 4'd1;
                            end
                        end
                        CYC: begin
                            if (idx_reg == 4'd2) begin
                                cycle_valid_reg <= 1'b1;
                                cycle_num_reg   <= cyc_cat;
                                state_reg       <= IDLE;
                            end else begin
                                cyc_sh[idx_reg[0]] <= payload;
                                idx_reg            <= idx_reg + 4'd1;
                            end
                        end
                        default: begin
                            err_cnt_reg <= sat_inc(err_cnt_reg);
                            state_reg   <= IDLE;
                        end
                    endcase
                end else begin
                    err_cnt_reg <= sat_inc(err_cnt_reg);
                    state_reg   <= IDLE;
                end
            end else if (state_reg == IDLE) begin
                stall_reg <= '0;
            end else if (TIMEOUT != 0) begin
                if (stall_reg == STALL_LAST) begin
                    err_cnt_reg <= sat_inc(err_cnt_reg);
                    state_reg   <= IDLE;
                    stall_reg   <= '0;
                end else begin
                    stall_reg <= stall_reg + 1'b1;
                end
            end
        end
    end

    assign bus.fifo_rd     = fifo_rd_reg;
    assign bus.trig_valid  = trig_valid_reg;
    assign bus.trig_num    = trig_num_reg;
    assign bus.trig_time   = trig_time_reg;
    assign bus.cycle_valid = cycle_valid_reg;
    assign bus.cycle_num   = cycle_num_reg;
    assign bus.err_cnt     = err_cnt_reg;
endmodule

// File: tb/tb_fifo_unpack.sv
// Directed bench for fifo_unpack: a byte FIFO model feeds hand-built packets,
// each scenario task checks pulses, decoded words and the error counter.
module tb_fifo_unpack;
    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_unpack_if #(.ERRW(4)) bus ();

    fifo_unpack #(
        .TIMEOUT(16),
        .ERRW   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // FIFO model: pops on a registered read, data appears one clk later.
    // Empty also looks ahead one pop so back-to-back reads never underflow.
    logic [7:0] mem [0:511];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] fifo_data_q = 8'h00;
    logic       empty_q = 1'b1;

    assign bus.fifo_data  = fifo_data_q;
    assign bus.fifo_empty = empty_q;

    always @(posedge clk) begin
        if (bus.fifo_rd === 1'b1 && rd_ptr != wr_ptr) begin
            fifo_data_q <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        empty_q <= (wr_ptr == rd_ptr) || ((wr_ptr - rd_ptr == 1) && (bus.fifo_rd === 1'b1));
    end

    // Pulse monitor, sampled on the falling edge.
    int  trig_seen = 0;
    int  cyc_seen  = 0;
    int  both_seen = 0;
    time trig_t    = 0;
    time cyc_t     = 0;

    always @(negedge clk) begin
        if (bus.trig_valid === 1'b1) begin
            trig_seen <= trig_seen + 1;
            trig_t    <= $time;
        end
        if (bus.cycle_valid === 1'b1) begin
            cyc_seen <= cyc_seen + 1;
            cyc_t    <= $time;
        end
        if (bus.trig_valid === 1'b1 && bus.cycle_valid === 1'b1)
            both_seen <= both_seen + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic push_bytes(input bq_t v);
        foreach (v[i]) begin
            mem[wr_ptr] = v[i];
            wr_ptr      = wr_ptr + 1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(3);
        checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b expected 0", bus.fifo_rd); end
        checks++; if (bus.trig_valid !== 1'b0) begin errors++; $display("FAIL reset_trig_valid: got %b expected 0", bus.trig_valid); end
        checks++; if (bus.cycle_valid !== 1'b0) begin errors++; $display("FAIL reset_cycle_valid: got %b expected 0", bus.cycle_valid); end
        checks++; if (bus.trig_num !== 18'h0) begin errors++; $display("FAIL reset_trig_num: got %h expected 0", bus.trig_num); end
        checks++; if (bus.trig_time !== 36'h0) begin errors++; $display("FAIL reset_trig_time: got %h expected 0", bus.trig_time); end
        checks++; if (bus.cycle_num !== 18'h0) begin errors++; $display("FAIL reset_cycle_num: got %h expected 0", bus.cycle_num); end
        checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 0", bus.err_cnt); end
        rst_n = 1'b1;
        wait_cycles(2);
        $display("test_reset done");
    endtask

    task automatic test_trigger();
        bq_t v;
        int  t0 = trig_seen;
        int  c0 = cyc_seen;
        v = '{8'hFF, 8'h03, 8'h17, 8'h2A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        push_bytes(v);
        wait_cycles(30);
        checks++; if (trig_seen - t0 !== 1) begin errors++; $display("FAIL trig_pulses: got %0d expected 1", trig_seen - t0); end
        checks++; if (cyc_seen - c0 !== 0) begin errors++; $display("FAIL trig_cyc_pulses: got %0d expected 0", cyc_seen - c0); end
        checks++; if (bus.trig_num !== 18'h2A5C3) begin errors++; $display("FAIL trig_num: got %h expected 2a5c3", bus.trig_num); end
        checks++; if (bus.trig_time !== 36'h000000041) begin errors++; $display("FAIL trig_time: got %h expected 000000041", bus.trig_time); end
        checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL trig_err_cnt: got %h expected 0", bus.err_cnt); end
        $display("test_trigger: trig_num=%h trig_time=%h", bus.trig_num, bus.trig_time);
    endtask

    task automatic test_back_to_back();
        bq_t v;
        int  t0, c0, b0;
        pulse_reset();
        t0 = trig_seen; c0 = cyc_seen; b0 = both_seen;
        v = '{8'hFF, 8'h03, 8'h17, 8'h2A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hBF, 8'h00, 8'h01, 8'h00};
        push_bytes(v);
        wait_cycles(40);
        checks++; if (trig_seen - t0 !== 1) begin errors++; $display("FAIL b2b_trig_pulses: got %0d expected 1", trig_seen - t0); end
        checks++; if (cyc_seen - c0 !== 1) begin errors++; $display("FAIL b2b_cyc_pulses: got %0d expected 1", cyc_seen - c0); end
        checks++; if (!(trig_t < cyc_t)) begin errors++; $display("FAIL b2b_order: trig at %0t cycle at %0t, required trig first", trig_t, cyc_t); end
        checks++; if (both_seen - b0 !== 0) begin errors++; $display("FAIL b2b_both_valid: got %0d expected 0", both_seen - b0); end
        checks++; if (bus.cycle_num !== 18'h00040) begin errors++; $display("FAIL b2b_cycle_num: got %h expected 00040", bus.cycle_num); end
        checks++; if (bus.trig_num !== 18'h2A5C3) begin errors++; $display("FAIL b2b_trig_num_hold: got %h expected 2a5c3", bus.trig_num); end
        checks++; if (bus.trig_time !== 36'h000000041) begin errors++; $display("FAIL b2b_trig_time_hold: got %h expected 000000041", bus.trig_time); end
        checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL b2b_err_cnt: got %h expected 0", bus.err_cnt); end
        $display("test_back_to_back: cycle_num=%h", bus.cycle_num);
    endtask

    task automatic test_truncated();
        bq_t v;
        int  t0, c0;
        pulse_reset();
        t0 = trig_seen; c0 = cyc_seen;
        v = '{8'hFF, 8'h05, 8'h05, 8'hBF, 8'h3F, 8'h3F, 8'h3F};
        push_bytes(v);
        wait_cycles(25);
        checks++; if (trig_seen - t0 !== 0) begin errors++; $display("FAIL trunc_trig_pulses: got %0d expected 0", trig_seen - t0); end
        checks++; if (cyc_seen - c0 !== 1) begin errors++; $display("FAIL trunc_cyc_pulses: got %0d expected 1", cyc_seen - c0); end
        checks++; if (bus.cycle_num !== 18'h3FFFF) begin errors++; $display("FAIL trunc_cycle_num: got %h expected 3ffff", bus.cycle_num); end
        checks++; if (bus.trig_num !== 18'h0) begin errors++; $display("FAIL trunc_trig_num: got %h expected 0", bus.trig_num); end
        checks++; if (bus.err_cnt !== 4'h1) begin errors++; $display("FAIL trunc_err_cnt: got %h expected 1", bus.err_cnt); end
        $display("test_truncated: err_cnt=%0d", bus.err_cnt);
    endtask

    task automatic test_garbage();
        bq_t v;
        int  t0, c0;
        pulse_reset();
        t0 = trig_seen; c0 = cyc_seen;
        v = '{8'h12, 8'h80};
        push_bytes(v);
        wait_cycles(10);
        checks++; if (bus.err_cnt !== 4'h2) begin errors++; $display("FAIL garb_idle_err: got %h expected 2", bus.err_cnt); end
        v = '{8'hFF, 8'h01, 8'hC0};
        push_bytes(v);
        wait_cycles(10);
        checks++; if (bus.err_cnt !== 4'h3) begin errors++; $display("FAIL garb_illegal_err: got %h expected 3", bus.err_cnt); end
        v = '{8'hBF, 8'h05, 8'h0A, 8'h0F};
        push_bytes(v);
        wait_cycles(12);
        checks++; if (trig_seen - t0 !== 0) begin errors++; $display("FAIL garb_trig_pulses: got %0d expected 0", trig_seen - t0); end
        checks++; if (cyc_seen - c0 !== 1) begin errors++; $display("FAIL garb_cyc_pulses: got %0d expected 1", cyc_seen - c0); end
        checks++; if (bus.cycle_num !== 18'h0F285) begin errors++; $display("FAIL garb_cycle_num: got %h expected 0f285", bus.cycle_num); end
        checks++; if (bus.err_cnt !== 4'h3) begin errors++; $display("FAIL garb_final_err: got %h expected 3", bus.err_cnt); end
        $display("test_garbage: err_cnt=%0d cycle_num=%h", bus.err_cnt, bus.cycle_num);
    endtask

    task automatic test_timeout();
        bq_t v;
        int  t0;
        pulse_reset();
        t0 = trig_seen;
        // Short stall mid-packet must not abort.
        v = '{8'hFF, 8'h01};
        push_bytes(v);
        wait_cycles(10);
        checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL tmo_short_stall_err: got %h expected 0", bus.err_cnt); end
        v = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        push_bytes(v);
        wait_cycles(20);
        checks++; if (trig_seen - t0 !== 1) begin errors++; $display("FAIL tmo_short_pulses: got %0d expected 1", trig_seen - t0); end
        checks++; if (bus.trig_num !== 18'h03081) begin errors++; $display("FAIL tmo_short_num: got %h expected 03081", bus.trig_num); end
        checks++; if (bus.trig_time !== 36'h2481C6144) begin errors++; $display("FAIL tmo_short_time: got %h expected 2481c6144", bus.trig_time); end
        // Long stall: packet abandoned after the timeout.
        v = '{8'hFF, 8'h01};
        push_bytes(v);
        wait_cycles(30);
        checks++; if (bus.err_cnt !== 4'h1) begin errors++; $display("FAIL tmo_err_cnt: got %h expected 1", bus.err_cnt); end
        checks++; if (trig_seen - t0 !== 1) begin errors++; $display("FAIL tmo_no_pulse: got %0d expected 1", trig_seen - t0); end
        v = '{8'hFF, 8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
        push_bytes(v);
        wait_cycles(25);
        checks++; if (trig_seen - t0 !== 2) begin errors++; $display("FAIL tmo_fresh_pulses: got %0d expected 2", trig_seen - t0); end
        checks++; if (bus.trig_num !== 18'h3FFFF) begin errors++; $display("FAIL tmo_fresh_num: got %h expected 3ffff", bus.trig_num); end
        checks++; if (bus.trig_time !== 36'hFC0000000) begin errors++; $display("FAIL tmo_fresh_time: got %h expected fc0000000", bus.trig_time); end
        checks++; if (bus.err_cnt !== 4'h1) begin errors++; $display("FAIL tmo_fresh_err: got %h expected 1", bus.err_cnt); end
        $display("test_timeout: err_cnt=%0d trig_num=%h", bus.err_cnt, bus.trig_num);
    endtask

    task automatic test_reset_mid_packet();
        bq_t v;
        int  t0;
        t0 = trig_seen;
        v = '{8'hFF, 8'h01, 8'h02};
        push_bytes(v);
        wait_cycles(8);
        pulse_reset();
        checks++; if (bus.trig_num !== 18'h0) begin errors++; $display("FAIL rmid_trig_num: got %h expected 0", bus.trig_num); end
        checks++; if (bus.trig_time !== 36'h0) begin errors++; $display("FAIL rmid_trig_time: got %h expected 0", bus.trig_time); end
        checks++; if (bus.cycle_num !== 18'h0) begin errors++; $display("FAIL rmid_cycle_num: got %h expected 0", bus.cycle_num); end
        checks++; if (bus.err_cnt !== 4'h0) begin errors++; $display("FAIL rmid_err_cnt: got %h expected 0", bus.err_cnt); end
        checks++; if (bus.trig_valid !== 1'b0 || bus.cycle_valid !== 1'b0) begin errors++; $display("FAIL rmid_valids: got %b%b expected 00", bus.trig_valid, bus.cycle_valid); end
        v = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_bytes(v);
        wait_cycles(20);
        checks++; if (bus.err_cnt !== 4'h6) begin errors++; $display("FAIL rmid_body_errs: got %h expected 6", bus.err_cnt); end
        checks++; if (trig_seen - t0 !== 0) begin errors++; $display("FAIL rmid_trig_pulses: got %0d expected 0", trig_seen - t0); end
        $display("test_reset_mid_packet: err_cnt=%0d", bus.err_cnt);
    endtask

    task automatic test_saturation();
        bq_t v;
        pulse_reset();
        v = {};
        for (int i = 0; i < 14; i++) v.push_back(8'hC0);
        push_bytes(v);
        wait_cycles(25);
        checks++; if (bus.err_cnt !== 4'hE) begin errors++; $display("FAIL sat_partial: got %h expected e", bus.err_cnt); end
        v = {};
        for (int i = 0; i < 6; i++) v.push_back(8'hC0);
        push_bytes(v);
        wait_cycles(15);
        checks++; if (bus.err_cnt !== 4'hF) begin errors++; $display("FAIL sat_no_wrap: got %h expected f", bus.err_cnt); end
        $display("test_saturation: err_cnt=%0d", bus.err_cnt);
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_back_to_back();
        test_truncated();
        test_garbage();
        test_timeout();
        test_reset_mid_packet();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
